// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC holder fetching bytes over req/ack into a FIFO with a valid/ready output.
// Define FETCH_BYPASS_EN to forward an acked byte straight to inst when the FIFO is empty.
module inst_fetch_unit #(
    parameter int ADDR_W     = 8,
    parameter int RESET_PC   = 0,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [7:0]        mem_data_i,
    output logic [7:0]        inst_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              halted_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = FIFO_DEPTH[CW-1:0];
    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     rd_q, wr_q;
    logic [7:0]        fifo_q [FIFO_DEPTH];
    logic              ack, is_halt, empty, byp, push, pop;
    assign ack     = state_q == FETCH && mem_ack_i;
    assign is_halt = &mem_data_i[7:3];
    assign empty   = cnt_q == '0;
`ifdef FETCH_BYPASS_EN
    assign byp = empty && ack && !is_halt;
`else
    assign byp = 1'b0;
`endif
    assign pop   = !empty && inst_ready_i;
    // A bypassed byte that is consumed immediately never occupies a slot
    assign push  = ack && !is_halt && !(byp && inst_ready_i);
    assign cnt_d = cnt_q + CW'(push) - CW'(pop);
    assign pc_d  = (ack && !is_halt) ? pc_q + 1'b1 : pc_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end
    // Requests only start with a free slot, and nothing is pushed while waiting, so the ack always fits
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE)
            state_d = (run_i && cnt_q != FULL) ? FETCH : IDLE;
        else if (ack)
            state_d = is_halt ? HALT : (run_i && cnt_d != FULL) ? FETCH : IDLE;
    end
    always_comb begin
        mem_req_o    = state_q == FETCH;
        mem_addr_o   = pc_q;
        pc_o         = pc_q;
        halted_o     = state_q == HALT;
        inst_valid_o = !empty || byp;
        inst_o       = !empty ? fifo_q[rd_q] : byp ? mem_data_i : 8'h00;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC[ADDR_W-1:0];
            cnt_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_q] <= mem_data_i;
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: scoreboard bench for inst_fetch_unit with a behavioural program memory.
module tb_inst_fetch_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run_i = 1'b0;
    logic       mem_req_o, mem_ack_i = 1'b0;
    logic [7:0] mem_addr_o, mem_data_i = 8'h00;
    logic [7:0] inst_o, pc_o;
    logic       inst_valid_o, inst_ready_i = 1'b0, halted_o;
    logic       run5 = 1'b0, ack5 = 1'b0, ready5 = 1'b1;
    logic [7:0] data5 = 8'h00, inst5;
    logic [2:0] addr5, pc5;
    logic       req5, valid5, halted5;
    logic [7:0] prog [256];
    logic [7:0] exp_q [$];
    logic [7:0] addr_log [$];
    int         ack_dly = 0, wait_cnt = 0;
    int         n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
    inst_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .run_i(run_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .inst_o(inst_o), .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .pc_o(pc_o), .halted_o(halted_o)
    );
    inst_fetch_unit #(.ADDR_W(3), .RESET_PC(7)) u5 (
        .clk(clk), .rst_n(rst_n), .run_i(run5),
        .mem_req_o(req5), .mem_addr_o(addr5),
        .mem_ack_i(ack5), .mem_data_i(data5),
        .inst_o(inst5), .inst_valid_o(valid5), .inst_ready_i(ready5),
        .pc_o(pc5), .halted_o(halted5)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // Program memory: acks after ack_dly idle cycles of a held request
    always @(posedge clk) begin
        #1;
        if (!rst_n || !mem_req_o) begin
            mem_ack_i = 1'b0;
            wait_cnt  = 0;
        end else if (wait_cnt >= ack_dly) begin
            mem_ack_i  = 1'b1;
            mem_data_i = prog[mem_addr_o];
            addr_log.push_back(mem_addr_o);
            wait_cnt   = 0;
        end else begin
            mem_ack_i = 1'b0;
            wait_cnt++;
        end
    end
    always @(negedge clk) begin
        if (rst_n) begin
            if (!inst_valid_o) chk("inst_idle_zero", inst_o, 8'h00);
            else if (inst_ready_i) begin
                chk("sb_pop_available", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("sb_inst", inst_o, exp_q.pop_front());
            end
        end
    end
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        run_i = 1'b0;
        run5  = 1'b0;
        exp_q.delete();
        foreach (prog[i]) prog[i] = 8'h00;
        tick(2);
        addr_log.delete();
        rst_n = 1'b1;
    endtask
    task automatic wait_req(input string name);
        @(negedge clk);
        for (int i = 0; i < 40 && !mem_req_o; i++) @(negedge clk);
        chk(name, mem_req_o, 1);
    endtask
    task automatic wait_halt(input string name);
        for (int i = 0; i < 60 && !halted_o; i++) @(negedge clk);
        chk(name, halted_o, 1);
    endtask
    initial begin
        int reqs;
        #3;
        chk("rst_memreq", mem_req_o, 0);
        chk("rst_valid", inst_valid_o, 0);
        chk("rst_inst", inst_o, 8'h00);
        chk("rst_halted", halted_o, 0);
        chk("rst_pc", pc_o, 0);
        // Test 1: back-to-back fetch with zero-wait memory
        do_reset();
        prog[0] = 8'h08; prog[1] = 8'h29; prog[2] = 8'h3A; prog[3] = 8'hF8;
        ack_dly = 0; inst_ready_i = 1'b1;
        exp_q.push_back(8'h08); exp_q.push_back(8'h29); exp_q.push_back(8'h3A);
        run_i = 1'b1;
        wait_halt("t1_halt");
        tick(3);
        chk("t1_pc", pc_o, 3);
        chk("t1_drained", exp_q.size(), 0);
        chk("t1_naddr", addr_log.size(), 4);
        for (int i = 0; i < 3 && i < addr_log.size(); i++) chk("t1_addr", addr_log[i], i);
        // Test 2: consumer stalls, FIFO fills, fetching pauses then resumes
        do_reset();
        prog[0] = 8'h41; prog[1] = 8'h52; prog[2] = 8'h63; prog[3] = 8'hF9;
        inst_ready_i = 1'b0;
        exp_q.push_back(8'h41); exp_q.push_back(8'h52); exp_q.push_back(8'h63);
        run_i = 1'b1;
        tick(8);
        chk("t2_req_full", mem_req_o, 0);
        chk("t2_pc_full", pc_o, 2);
        chk("t2_head", inst_o, 8'h41);
        inst_ready_i = 1'b1;
        wait_req("t2_resume_req");
        chk("t2_resume_addr", mem_addr_o, 2);
        wait_halt("t2_halt");
        tick(3);
        chk("t2_pc", pc_o, 3);
        chk("t2_drained", exp_q.size(), 0);
        // Test 3: slow memory, request held stable
        do_reset();
        prog[0] = 8'h77; prog[1] = 8'hFA;
        ack_dly = 3; inst_ready_i = 1'b1;
        exp_q.push_back(8'h77);
        run_i = 1'b1;
        wait_req("t3_req");
        for (int k = 0; k < 3; k++) begin
            chk("t3_req_held", mem_req_o, 1);
            chk("t3_addr_held", mem_addr_o, 0);
            chk("t3_no_ack", mem_ack_i, 0);
            chk("t3_no_valid", inst_valid_o, 0);
            @(negedge clk);
        end
        wait_halt("t3_halt");
        tick(3);
        chk("t3_drained", exp_q.size(), 0);
        // Test 4: HALT stops fetching
        do_reset();
        prog[0] = 8'h10; prog[1] = 8'hF8; prog[2] = 8'h20; prog[3] = 8'hF8;
        ack_dly = 0; inst_ready_i = 1'b1;
        exp_q.push_back(8'h10);
        run_i = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 30 && !(mem_req_o && mem_ack_i && mem_data_i == 8'hF8); i++) @(negedge clk);
        chk("t4_halt_ack_seen", mem_ack_i && mem_data_i == 8'hF8, 1);
        chk("t4_not_yet_halted", halted_o, 0);
        @(negedge clk);
        chk("t4_halted", halted_o, 1);
        chk("t4_pc", pc_o, 1);
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req_o) reqs++;
        end
        chk("t4_no_req", reqs, 0);
        chk("t4_still_halted", halted_o, 1);
        chk("t4_drained", exp_q.size(), 0);
        // Test 5: 3-bit PC wraps from 7 to 0
        do_reset();
        run5 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20 && !req5; i++) @(negedge clk);
        chk("t5_req", req5, 1);
        chk("t5_addr7", addr5, 7);
        ack5 = 1'b1; data5 = 8'h01;
        @(posedge clk);
        #1 ack5 = 1'b0;
        @(negedge clk);
        chk("t5_pc_wrap", pc5, 0);
        chk("t5_req_next", req5, 1);
        chk("t5_addr_wrap", addr5, 0);
        // Test 6: run dropped mid-request, then async reset mid-request
        do_reset();
        prog[0] = 8'h55; prog[1] = 8'h66;
        ack_dly = 3; inst_ready_i = 1'b0;
        run_i = 1'b1;
        wait_req("t6_req");
        run_i = 1'b0;
        @(negedge clk);
        chk("t6_req_kept", mem_req_o, 1);
        for (int i = 0; i < 10 && !mem_ack_i; i++) @(negedge clk);
        chk("t6_ack", mem_ack_i, 1);
        @(negedge clk);
        chk("t6_idle", mem_req_o, 0);
        chk("t6_pc", pc_o, 1);
        chk("t6_valid", inst_valid_o, 1);
        chk("t6_head", inst_o, 8'h55);
        tick(3);
        chk("t6_stay_idle", mem_req_o, 0);
        run_i = 1'b1;
        wait_req("t6_req2");
        chk("t6_addr2", mem_addr_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_req", mem_req_o, 0);
        chk("t6_rst_valid", inst_valid_o, 0);
        chk("t6_rst_pc", pc_o, 0);
        chk("t6_rst_inst", inst_o, 8'h00);
`ifdef FETCH_BYPASS_EN
        // Bypass: byte appears in the ack cycle
        do_reset();
        prog[0] = 8'h28; prog[1] = 8'hFB;
        ack_dly = 2; inst_ready_i = 1'b1;
        exp_q.push_back(8'h28);
        run_i = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20 && !mem_ack_i; i++) @(negedge clk);
        chk("byp_valid", inst_valid_o, 1);
        chk("byp_inst", inst_o, 8'h28);
        wait_halt("byp_halt");
        tick(2);
        chk("byp_drained", exp_q.size(), 0);
`endif
        do_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
